// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and a ceil-log2 helper.
// Used by both the transmit and receive paths.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Smallest width able to hold value-1, never less than one bit.
  function automatic int clog2(input int value);
    int result;
    result = 1;
    for (int i = 1; i < 31; i++) begin
      if (int'(32'd1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the last clock of each bit.
// The count wraps to zero on its own at every bit boundary.
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter  int CLKS_PER_BIT = 868,
  localparam int CNT_W        = clog2(CLKS_PER_BIT)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             enable_i,
  output logic [CNT_W-1:0] count_o,
  output logic             bit_end_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] r_count;

  // Baud count register; clear wins over enable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= {CNT_W{1'b0}};
    end else if (clear_i) begin
      r_count <= {CNT_W{1'b0}};
    end else if (enable_i) begin
      if (r_count == CNT_MAX) begin
        r_count <= {CNT_W{1'b0}};
      end else begin
        r_count <= r_count + CNT_W'(1);
      end
    end else begin
      r_count <= r_count;
    end
  end

  assign count_o   = r_count;
  assign bit_end_o = enable_i && (r_count == CNT_MAX);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: accepts a word over valid/ready and sends it LSB first as
// start, data, optional parity and stop bits on an idle-high, flop-driven line.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [DATA_BITS-1:0] tx_data_i,
  input  logic                 tx_valid_i,
  output logic                 tx_ready_o,
  output logic                 tx_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int CNT_W = clog2(CLKS_PER_BIT);
  localparam int BIT_W = clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_PRE   = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 8 ||
      PARITY_MODE < 0 || PARITY_MODE > 2 || (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_param_check
    $error("uart_tx: illegal parameter value");
  end

  uart_state_t          r_state, w_state_next;
  logic [DATA_BITS-1:0] r_shift, w_shift_next;
  logic [BIT_W-1:0]     r_bit_cnt, w_bit_cnt_next;
  logic                 r_stop_cnt, w_stop_cnt_next;
  logic                 r_parity, w_parity_next;
  logic                 r_tx, w_tx_next;
  logic                 r_ready, w_ready_next;
  logic                 r_busy, w_busy_next;
  logic                 r_done, w_done_next;
  logic [CNT_W-1:0]     w_count;
  logic                 w_bit_end;

  uart_baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (r_state == ST_IDLE),
    .enable_i  (r_state != ST_IDLE),
    .count_o   (w_count),
    .bit_end_o (w_bit_end)
  );

  // Next-state and next-output logic; outputs are computed one cycle ahead and registered.
  always_comb begin
    w_state_next    = r_state;
    w_shift_next    = r_shift;
    w_bit_cnt_next  = r_bit_cnt;
    w_stop_cnt_next = r_stop_cnt;
    w_parity_next   = r_parity;
    w_tx_next       = r_tx;
    w_ready_next    = r_ready;
    w_busy_next     = r_busy;
    w_done_next     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_tx_next    = 1'b1;
        w_ready_next = 1'b1;
        w_busy_next  = 1'b0;
        if (tx_valid_i && r_ready) begin
          w_shift_next    = tx_data_i;
          w_bit_cnt_next  = {BIT_W{1'b0}};
          w_stop_cnt_next = 1'b0;
          if (PARITY_MODE == PARITY_ODD) begin
            w_parity_next = ~^tx_data_i;
          end else if (PARITY_MODE == PARITY_EVEN) begin
            w_parity_next = ^tx_data_i;
          end else begin
            w_parity_next = 1'b0;
          end
          w_state_next = ST_START;
          w_tx_next    = 1'b0;
          w_ready_next = 1'b0;
          w_busy_next  = 1'b1;
        end
      end
      ST_START: begin
        if (w_bit_end) begin
          w_tx_next      = r_shift[0];
          w_shift_next   = {1'b0, r_shift[DATA_BITS-1:1]};
          w_bit_cnt_next = {BIT_W{1'b0}};
          w_state_next   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          if (r_bit_cnt == BIT_LAST) begin
            w_stop_cnt_next = 1'b0;
            if (PARITY_MODE != PARITY_NONE) begin
              w_tx_next    = r_parity;
              w_state_next = ST_PARITY;
            end else begin
              w_tx_next    = 1'b1;
              w_state_next = ST_STOP;
            end
          end else begin
            w_bit_cnt_next = r_bit_cnt + BIT_W'(1);
            w_tx_next      = r_shift[0];
            w_shift_next   = {1'b0, r_shift[DATA_BITS-1:1]};
          end
        end
      end
      ST_PARITY: begin
        if (w_bit_end) begin
          w_tx_next       = 1'b1;
          w_stop_cnt_next = 1'b0;
          w_state_next    = ST_STOP;
        end
      end
      ST_STOP: begin
        // Registered done must be raised one cycle early to land on the final stop clock.
        if (r_stop_cnt == STOP_LAST && w_count == CNT_PRE) begin
          w_done_next = 1'b1;
        end
        if (w_bit_end) begin
          if (r_stop_cnt == STOP_LAST) begin
            w_state_next = ST_IDLE;
            w_tx_next    = 1'b1;
            w_ready_next = 1'b1;
            w_busy_next  = 1'b0;
          end else begin
            w_stop_cnt_next = 1'b1;
          end
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_tx_next    = 1'b1;
        w_ready_next = 1'b0;
        w_busy_next  = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= ST_IDLE;
      r_shift    <= {DATA_BITS{1'b0}};
      r_bit_cnt  <= {BIT_W{1'b0}};
      r_stop_cnt <= 1'b0;
      r_parity   <= 1'b0;
      r_tx       <= 1'b1;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_shift    <= w_shift_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_stop_cnt <= w_stop_cnt_next;
      r_parity   <= w_parity_next;
      r_tx       <= w_tx_next;
      r_ready    <= w_ready_next;
      r_busy     <= w_busy_next;
      r_done     <= w_done_next;
    end
  end

  assign tx_o       = r_tx;
  assign tx_ready_o = r_ready;
  assign busy_o     = r_busy;
  assign done_o     = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances (8N1, 8E1, 8O1, 5N2) at 4 clocks per bit,
// checked cycle by cycle against hand-computed line patterns.
module tb_uart_tx;

  localparam int CPB = 4;

  typedef struct {
    int          sel;
    logic [7:0]  data;
    logic [15:0] line;   // bit i = line level during bit period i
    int          len;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] r_data [4];
  logic [3:0] r_valid;
  logic [3:0] w_tx, w_ready, w_busy, w_done;

  int n_checks;
  int n_errors;
  vec_t vecs [5];

  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
    .clk_i(clk), .rst_ni(rst_n), .tx_data_i(r_data[0]), .tx_valid_i(r_valid[0]),
    .tx_ready_o(w_ready[0]), .tx_o(w_tx[0]), .busy_o(w_busy[0]), .done_o(w_done[0]));
  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u_8e1 (
    .clk_i(clk), .rst_ni(rst_n), .tx_data_i(r_data[1]), .tx_valid_i(r_valid[1]),
    .tx_ready_o(w_ready[1]), .tx_o(w_tx[1]), .busy_o(w_busy[1]), .done_o(w_done[1]));
  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_8o1 (
    .clk_i(clk), .rst_ni(rst_n), .tx_data_i(r_data[2]), .tx_valid_i(r_valid[2]),
    .tx_ready_o(w_ready[2]), .tx_o(w_tx[2]), .busy_o(w_busy[2]), .done_o(w_done[2]));
  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(5), .PARITY_MODE(0), .STOP_BITS(2)) u_5n2 (
    .clk_i(clk), .rst_ni(rst_n), .tx_data_i(r_data[3][4:0]), .tx_valid_i(r_valid[3]),
    .tx_ready_o(w_ready[3]), .tx_o(w_tx[3]), .busy_o(w_busy[3]), .done_o(w_done[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Called on a falling edge; waits a bounded time for ready.
  task automatic wait_ready(input int sel);
    for (int i = 0; i < 200 && !w_ready[sel]; i++) @(negedge clk);
    chk($sformatf("ready_wait u%0d", sel), 32'(w_ready[sel]), 32'd1);
  endtask

  // Presents a word, returns #1 after the accept edge with the data bus scrambled.
  task automatic start_frame(input int sel, input logic [7:0] d);
    wait_ready(sel);
    r_data[sel]  = d;
    r_valid[sel] = 1'b1;
    @(posedge clk);
    #1;
    r_valid[sel] = 1'b0;
    r_data[sel]  = ~d;
  endtask

  // Checks every cycle of a frame plus the idle cycle after it; cycle 1 is the one after accept.
  task automatic check_frame(input int sel, input logic [15:0] line, input int len);
    for (int k = 1; k <= len + 1; k++) begin
      @(negedge clk);
      if (k <= len) begin
        chk($sformatf("tx u%0d c%0d", sel, k), 32'(w_tx[sel]), 32'(line[(k-1)/CPB]));
        chk($sformatf("busy u%0d c%0d", sel, k), 32'(w_busy[sel]), 32'd1);
        chk($sformatf("ready u%0d c%0d", sel, k), 32'(w_ready[sel]), 32'd0);
        chk($sformatf("done u%0d c%0d", sel, k), 32'(w_done[sel]), 32'(k == len));
      end else begin
        chk($sformatf("idle_tx u%0d", sel), 32'(w_tx[sel]), 32'd1);
        chk($sformatf("idle_busy u%0d", sel), 32'(w_busy[sel]), 32'd0);
        chk($sformatf("idle_ready u%0d", sel), 32'(w_ready[sel]), 32'd1);
        chk($sformatf("idle_done u%0d", sel), 32'(w_done[sel]), 32'd0);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    r_valid  = 4'b0000;
    for (int i = 0; i < 4; i++) r_data[i] = 8'h00;

    vecs[0] = '{sel: 0, data: 8'hA5, line: 16'h034A, len: 40};  // 8N1
    vecs[1] = '{sel: 1, data: 8'hA5, line: 16'h054A, len: 44};  // 8E1, parity 0
    vecs[2] = '{sel: 2, data: 8'hA5, line: 16'h074A, len: 44};  // 8O1, parity 1
    vecs[3] = '{sel: 1, data: 8'h07, line: 16'h060E, len: 44};  // 8E1, parity 1
    vecs[4] = '{sel: 3, data: 8'h1F, line: 16'h00FE, len: 32};  // 5N2

    // Reset values, then ready one edge after release.
    #12;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_tx u%0d", i), 32'(w_tx[i]), 32'd1);
      chk($sformatf("rst_ready u%0d", i), 32'(w_ready[i]), 32'd0);
      chk($sformatf("rst_busy u%0d", i), 32'(w_busy[i]), 32'd0);
      chk($sformatf("rst_done u%0d", i), 32'(w_done[i]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) chk($sformatf("rel_ready_pre u%0d", i), 32'(w_ready[i]), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) chk($sformatf("rel_ready_post u%0d", i), 32'(w_ready[i]), 32'd1);

    // Table-driven frames.
    for (int v = 0; v < 5; v++) begin
      start_frame(vecs[v].sel, vecs[v].data);
      check_frame(vecs[v].sel, vecs[v].line, vecs[v].len);
    end

    // Back-to-back with valid held high; data changes right after the first accept.
    wait_ready(0);
    r_data[0]  = 8'h00;
    r_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    r_data[0] = 8'hFF;
    check_frame(0, 16'h0200, 40);
    @(posedge clk);
    #1;
    r_valid[0] = 1'b0;
    check_frame(0, 16'h03FE, 40);

    // Valid pulsed while busy is ignored.
    start_frame(0, 8'hA5);
    fork
      check_frame(0, 16'h034A, 40);
      begin
        repeat (10) @(negedge clk);
        r_data[0]  = 8'hFF;
        r_valid[0] = 1'b1;
        @(negedge clk);
        r_valid[0] = 1'b0;
      end
    join
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("no_2nd_busy c%0d", k), 32'(w_busy[0]), 32'd0);
      chk($sformatf("no_2nd_tx c%0d", k), 32'(w_tx[0]), 32'd1);
    end

    // Asynchronous reset in the middle of data bit 3 of 0x5A, then a clean frame.
    start_frame(0, 8'h5A);
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      if (k == 14) chk("mid_bit2_tx", 32'(w_tx[0]), 32'd0);
    end
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_tx", 32'(w_tx[0]), 32'd1);
    chk("async_ready", 32'(w_ready[0]), 32'd0);
    chk("async_busy", 32'(w_busy[0]), 32'd0);
    chk("async_done", 32'(w_done[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rerel_ready_pre", 32'(w_ready[0]), 32'd0);
    @(negedge clk);
    chk("rerel_ready_post", 32'(w_ready[0]), 32'd1);
    chk("rerel_tx", 32'(w_tx[0]), 32'd1);
    start_frame(0, 8'h3C);
    check_frame(0, 16'h0278, 40);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
